// File: rtl/ssex_pkg.sv
// Shared ssex pipeline definitions: fetch-state encodings and instruction constants.
package ssex_pkg;
  localparam int                INST_W   = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;
  localparam logic [31:0]       PC_STEP  = 32'd4;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/if_fetch_ctrl.sv
// ssex instruction-fetch controller: owns the PC, drives the async ROM address and
// fills the IF/ID slot with a valid/ready handshake, handling stalls, redirects and halt.
module if_fetch_ctrl
  import ssex_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              start,
  input  logic              halt,
  output logic [31:0]       rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  input  logic              id_ready,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              id_valid,
  output logic [INST_W-1:0] id_inst,
  output logic [31:0]       id_pc,
  output logic [31:0]       id_pc4,
  output logic [CNT_W-1:0]  fetch_count,
  output logic              align_err,
  output logic              busy
);

  fetch_state_e      state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic              id_valid_q, id_valid_d;
  logic [INST_W-1:0] id_inst_q, id_inst_d;
  logic [31:0]       id_pc_q, id_pc_d;
  logic [31:0]       id_pc4_q, id_pc4_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              align_q, align_d;
  logic              fire;

  always_comb begin
    state_d = state_q;
    case (state_q)
      FS_IDLE: if (start) state_d = FS_RUN;
      FS_RUN:  if (halt)  state_d = FS_HALT;
      FS_HALT: if (start) state_d = FS_RUN;
      default:            state_d = FS_IDLE;  // 2'd3 recovers
    endcase
  end

  // A fetch needs a free (or simultaneously drained) slot and no pending redirect.
  assign fire = (state_q == FS_RUN) & ~halt & ~redirect_valid & (~id_valid_q | id_ready);

  always_comb begin
    pc_d       = pc_q;
    id_valid_d = id_valid_q;
    id_inst_d  = id_inst_q;
    id_pc_d    = id_pc_q;
    id_pc4_d   = id_pc4_q;
    cnt_d      = cnt_q;
    align_d    = align_q;
    if (redirect_valid) begin
      // Wrong-path flush; the target is fetched on the following edge.
      pc_d       = {redirect_pc[31:2], 2'b00};
      id_valid_d = 1'b0;
      if (redirect_pc[1:0] != 2'b00) align_d = 1'b1;
    end else if (fire) begin
      id_inst_d  = rom_inst;
      id_pc_d    = pc_q;
      id_pc4_d   = pc_q + PC_STEP;
      id_valid_d = 1'b1;
      pc_d       = pc_q + PC_STEP;
      cnt_d      = cnt_q + CNT_W'(1);
    end else if (id_valid_q && id_ready) begin
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= FS_IDLE;
      pc_q       <= RESET_PC;
      id_valid_q <= 1'b0;
      id_inst_q  <= NOP_INST;
      id_pc_q    <= '0;
      id_pc4_q   <= '0;
      cnt_q      <= '0;
      align_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      id_inst_q  <= id_inst_d;
      id_pc_q    <= id_pc_d;
      id_pc4_q   <= id_pc4_d;
      cnt_q      <= cnt_d;
      align_q    <= align_d;
    end
  end

  assign rom_addr    = pc_q;
  assign id_valid    = id_valid_q;
  assign id_inst     = id_inst_q;
  assign id_pc       = id_pc_q;
  assign id_pc4      = id_pc4_q;
  assign fetch_count = cnt_q;
  assign align_err   = align_q;
  assign busy        = (state_q == FS_RUN);

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl: stimulus queues the instructions ID should
// accept, a negedge monitor pops and compares on every id_valid & id_ready handshake.
module tb_if_fetch_ctrl;
  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        start = 1'b0, halt = 1'b0;
  logic [31:0] rom_addr, rom_inst;
  logic        id_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic [31:0] id_inst, id_pc, id_pc4;
  logic [15:0] fetch_count;
  logic        align_err, busy;

  logic [31:0] rom [0:63];
  assign rom_inst = rom[rom_addr[7:2]];

  if_fetch_ctrl #(.RESET_PC(32'h0), .CNT_W(16)) dut (
    .clk(clk), .clrn(clrn), .start(start), .halt(halt),
    .rom_addr(rom_addr), .rom_inst(rom_inst), .id_ready(id_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .id_pc4(id_pc4),
    .fetch_count(fetch_count), .align_err(align_err), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] I0 = 32'h00100c22, I1 = 32'h00101464, I2 = 32'h340014a7;
  localparam logic [31:0] R6 = 32'hA000_0006, R7 = 32'hA000_0007, R8 = 32'hA000_0008;

  int n_total = 0, n_pass = 0;
  logic [31:0] exp_inst_q [$];
  logic [31:0] exp_pc_q   [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic expect_acc(input logic [31:0] inst, input logic [31:0] pc);
    exp_inst_q.push_back(inst);
    exp_pc_q.push_back(pc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a handshake seen at negedge is the transfer the next posedge completes.
  always @(negedge clk) begin
    if (clrn && id_valid && id_ready) begin
      if (exp_inst_q.size() == 0) begin
        n_total++;
        $display("FAIL acc_unexpected: got inst %h pc %h expected no transfer", id_inst, id_pc);
      end else begin
        logic [31:0] ei, ep;
        ei = exp_inst_q.pop_front();
        ep = exp_pc_q.pop_front();
        chk("acc_inst", id_inst, ei);
        chk("acc_pc",   id_pc,   ep);
        chk("acc_pc4",  id_pc4,  ep + 32'd4);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hA000_0000 + 32'(i);
    rom[0] = I0; rom[1] = I1; rom[2] = I2;
    // Instructions ID will accept, in order (I2 is flushed by the redirect).
    expect_acc(I0, 32'h0);  expect_acc(I1, 32'h4);
    expect_acc(R6, 32'h18); expect_acc(R6, 32'h18); expect_acc(R7, 32'h1c);
    expect_acc(R8, 32'h20); expect_acc(I0, 32'h0);

    #12;
    chk("rst_valid", 32'(id_valid), 0);   chk("rst_inst", id_inst, 0);
    chk("rst_pc", id_pc, 0);              chk("rst_pc4", id_pc4, 0);
    chk("rst_cnt", 32'(fetch_count), 0);  chk("rst_align", 32'(align_err), 0);
    chk("rst_busy", 32'(busy), 0);        chk("rst_addr", rom_addr, 0);
    clrn = 1'b1;

    // Start and stream
    tick(); id_ready = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    chk("start_busy", 32'(busy), 1); chk("start_novalid", 32'(id_valid), 0);
    tick();
    chk("f0_valid", 32'(id_valid), 1); chk("f0_inst", id_inst, I0); chk("f0_pc", id_pc, 0);
    tick();
    id_ready = 1'b0;
    chk("f1_inst", id_inst, I1); chk("f1_pc", id_pc, 4); chk("f1_addr", rom_addr, 8);
    chk("f1_cnt", 32'(fetch_count), 2);

    // Stall for 3 cycles
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_valid", 32'(id_valid), 1); chk("stall_inst", id_inst, I1);
      chk("stall_pc", id_pc, 4);            chk("stall_addr", rom_addr, 8);
    end
    id_ready = 1'b1;
    tick();
    chk("f2_inst", id_inst, I2); chk("f2_pc", id_pc, 8); chk("f2_cnt", 32'(fetch_count), 3);

    // Redirect while stalled
    id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h18;
    tick();
    redirect_valid = 1'b0; id_ready = 1'b1;
    chk("rd_flush", 32'(id_valid), 0); chk("rd_addr", rom_addr, 32'h18);
    chk("rd_align", 32'(align_err), 0);
    tick();
    chk("rd_inst", id_inst, R6); chk("rd_pc", id_pc, 32'h18); chk("rd_valid", 32'(id_valid), 1);

    // Misaligned redirect (R6 is accepted on this same edge)
    redirect_valid = 1'b1; redirect_pc = 32'h1A;
    tick();
    redirect_valid = 1'b0;
    chk("mis_addr", rom_addr, 32'h18); chk("mis_align", 32'(align_err), 1);
    chk("mis_flush", 32'(id_valid), 0);
    tick();
    tick();
    chk("mis_sticky", 32'(align_err), 1); chk("mis_inst", id_inst, R7);
    chk("mis_cnt", 32'(fetch_count), 6);

    // Halt while stalled: slot holds, then drains, no more fetches
    id_ready = 1'b0; halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("h_busy", 32'(busy), 0); chk("h_valid", 32'(id_valid), 1);
    chk("h_inst", id_inst, R7);  chk("h_addr", rom_addr, 32'h20);
    tick();
    chk("h_hold", 32'(id_valid), 1);
    id_ready = 1'b1;
    tick();
    chk("h_drain", 32'(id_valid), 0); chk("h_cnt", 32'(fetch_count), 6);
    tick();
    chk("h_nofetch", 32'(fetch_count), 6); chk("h_still", 32'(id_valid), 0);

    // Resume from held pc
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("res_inst", id_inst, R8); chk("res_pc", id_pc, 32'h20);

    // start+halt together in RUN: halt wins
    start = 1'b1; halt = 1'b1;
    tick();
    start = 1'b0; halt = 1'b0;
    chk("sh_busy", 32'(busy), 0); chk("sh_valid", 32'(id_valid), 0);
    chk("sh_cnt", 32'(fetch_count), 7);

    // Async reset mid-fetch
    start = 1'b1;
    tick();
    start = 1'b0; id_ready = 1'b0;
    tick();
    #2 clrn = 1'b0;
    #1;
    chk("ar_valid", 32'(id_valid), 0);   chk("ar_inst", id_inst, 0);
    chk("ar_pc", id_pc, 0);              chk("ar_pc4", id_pc4, 0);
    chk("ar_cnt", 32'(fetch_count), 0);  chk("ar_align", 32'(align_err), 0);
    chk("ar_busy", 32'(busy), 0);        chk("ar_addr", rom_addr, 0);
    tick(); tick();
    #2 clrn = 1'b1;
    tick();
    id_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("rs_inst", id_inst, I0); chk("rs_pc", id_pc, 0);
    tick();
    chk("sb_empty", 32'(exp_inst_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
